// File: rtl/seq_mult4_pkg.sv
// Shared constants for the sequential 4x4 shift-and-add multiplier.
// Holds the operand width, counter width and FSM state encodings.
package seq_mult4_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult4_cla.sv
// 4-bit carry-lookahead adder with a 5-bit sum (bit 4 is the carry out).
// Used unchanged by seq_mult4 for every partial-product addition.
module cla (
    output logic [4:0] sum,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are flattened so no stage ripples through the previous one.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = {c[4], p ^ c[3:0]};

endmodule

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving a single cla adder.
// One add plus right shift per clock; start/busy/done handshake, registered outputs.
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t           state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] shifted;

    // A zero multiplier bit still adds zero through the adder; there is no bypass.
    assign addend  = mq[0] ? mcand : '0;
    assign shifted = {sum, mq[WIDTH-1:1]};

    cla u_cla (
        .sum (sum),
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc_hi  <= '0;
            mq      <= '0;
            mcand   <= '0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mq     <= b;
                        acc_hi <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= shifted[2*WIDTH-1:WIDTH];
                    mq     <= shifted[WIDTH-1:0];
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        product <= shifted;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
